// File: rtl/occupancy_map_updater.sv
// Occupancy grid updater: FIFO-buffered saturating log-odds RMW on a dual-port grid RAM,
// a read-only query port and a full-map clear. Define MAP_UPDATE_STATS_EN for update counters.
// state   | meaning
// S_IDLE  | waiting for a queued update or a pending clear
// S_READ  | port A read in flight for the popped entry
// S_WRITE | saturated result written back; may pop the next entry
// S_CLEAR | sweeping every address to zero
module occupancy_map_updater #(
    parameter int COORD_W    = 5,
    parameter int CELL_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int L_OCC      = 3,
    parameter int L_FREE     = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     upd_valid,
    input  logic                     upd_free,
    input  logic [COORD_W-1:0]       upd_x,
    input  logic [COORD_W-1:0]       upd_y,
    output logic                     upd_ready,
    input  logic                     clear_start,
    output logic                     clear_done,
    input  logic [COORD_W-1:0]       q_x,
    input  logic [COORD_W-1:0]       q_y,
    output logic signed [CELL_W-1:0] q_data,
    output logic                     busy,
    output logic                     overflow
`ifdef MAP_UPDATE_STATS_EN
    ,
    output logic [15:0]              stat_occ,
    output logic [15:0]              stat_free,
    output logic [15:0]              stat_sat
`endif
);
    localparam int AW = 2 * COORD_W;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + 1;
    localparam logic signed [CELL_W:0] MAXV = (CELL_W+1)'(2**(CELL_W-1) - 1);
    localparam logic signed [CELL_W:0] MINV = ~MAXV;
    localparam logic signed [CELL_W:0] INC  = (CELL_W+1)'(L_OCC);
    localparam logic signed [CELL_W:0] DEC  = (CELL_W+1)'(L_FREE);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_CLEAR} state_t;
    state_t state_q, state_d;

    logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [CELL_W-1:0] map_mem [2**AW];
    logic [PW-1:0]     wp_q, rp_q;
    logic [CW-1:0]     cnt_q;
    logic [AW-1:0]     cur_addr_q, clr_addr_q, head_addr, wa_a;
    logic [CELL_W-1:0] fwd_val_q, rd_mem_q, q_raw_q, wd_a, new_val;
    logic              cur_free_q, fwd_q, clear_pending_q, clear_done_q, overflow_q, q_vld_q;
    logic              fifo_empty, fifo_full, clear_req, clear_pend, clr_last;
    logic              pop, push, we_a, head_free, sat;
    logic signed [CELL_W:0] old_ext, res;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
    assign head_free  = fifo_mem[rp_q][EW-1];
    assign head_addr  = {fifo_mem[rp_q][COORD_W-1:0], fifo_mem[rp_q][AW-1:COORD_W]};
    assign clear_req  = clear_start && (state_q != S_CLEAR);
    assign clear_pend = clear_pending_q || clear_req;
    assign clr_last   = (clr_addr_q == '1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (clear_pend) state_d = S_CLEAR;
                     else if (!fifo_empty) state_d = S_READ;
            S_READ:  state_d = S_WRITE;
            S_WRITE: if (clear_pend) state_d = S_CLEAR;
                     else if (!fifo_empty) state_d = S_READ;
                     else state_d = S_IDLE;
            S_CLEAR: if (clr_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    always_comb begin
        pop       = (state_q == S_IDLE || state_q == S_WRITE) && !clear_pend && !fifo_empty;
        upd_ready = (!fifo_full || pop) && (state_q != S_CLEAR) && !clear_pending_q;
        push      = upd_valid && upd_ready && !clear_req;
        we_a      = (state_q == S_WRITE) || (state_q == S_CLEAR);
        wa_a      = (state_q == S_CLEAR) ? clr_addr_q : cur_addr_q;
        wd_a      = (state_q == S_CLEAR) ? '0 : new_val;
        busy      = !fifo_empty || (state_q != S_IDLE) || clear_pending_q;
    end

    always_comb begin
        old_ext = fwd_q ? {fwd_val_q[CELL_W-1], fwd_val_q} : {rd_mem_q[CELL_W-1], rd_mem_q};
        res     = cur_free_q ? (old_ext - DEC) : (old_ext + INC);
        sat     = cur_free_q ? (res < MINV) : (res > MAXV);
        new_val = res[CELL_W-1:0];
        if (sat) new_val = cur_free_q ? MINV[CELL_W-1:0] : MAXV[CELL_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (we_a) map_mem[wa_a] <= wd_a;
        if (pop)  rd_mem_q <= map_mem[head_addr];
        q_raw_q <= map_mem[{q_y, q_x}];
        if (push) fifo_mem[wp_q] <= {upd_free, upd_x, upd_y};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp_q            <= '0;
            rp_q            <= '0;
            cnt_q           <= '0;
            cur_addr_q      <= '0;
            cur_free_q      <= 1'b0;
            fwd_q           <= 1'b0;
            fwd_val_q       <= '0;
            clear_pending_q <= 1'b0;
            clr_addr_q      <= '0;
            clear_done_q    <= 1'b0;
            overflow_q      <= 1'b0;
            q_vld_q         <= 1'b0;
        end else begin
            q_vld_q      <= 1'b1;
            clear_done_q <= (state_q == S_CLEAR) && clr_last;
            if (clear_req) begin
                wp_q  <= '0;
                rp_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push) wp_q <= wp_q + 1'b1;
                if (pop)  rp_q <= rp_q + 1'b1;
                cnt_q <= cnt_q + CW'(push) - CW'(pop);
            end
            // Same-address back-to-back pop: the RAM read races this write, so keep the new value.
            if (pop) begin
                cur_addr_q <= head_addr;
                cur_free_q <= head_free;
                fwd_q      <= (state_q == S_WRITE) && (head_addr == cur_addr_q);
                fwd_val_q  <= new_val;
            end
            if (clear_req) clear_pending_q <= 1'b1;
            else if ((state_q == S_CLEAR) && clr_last) clear_pending_q <= 1'b0;
            if (state_q == S_CLEAR) clr_addr_q <= clr_addr_q + 1'b1;
            if (clear_req) overflow_q <= 1'b0;
            else if (upd_valid && !upd_ready) overflow_q <= 1'b1;
        end
    end

    assign clear_done = clear_done_q;
    assign overflow   = overflow_q;
    assign q_data     = q_vld_q ? q_raw_q : '0;

`ifdef MAP_UPDATE_STATS_EN
    logic [15:0] stat_occ_q, stat_free_q, stat_sat_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_occ_q  <= '0;
            stat_free_q <= '0;
            stat_sat_q  <= '0;
        end else if ((state_q == S_CLEAR) && clr_last) begin
            stat_occ_q  <= '0;
            stat_free_q <= '0;
            stat_sat_q  <= '0;
        end else if (state_q == S_WRITE) begin
            if (!cur_free_q && stat_occ_q != 16'hFFFF) stat_occ_q <= stat_occ_q + 16'd1;
            if (cur_free_q && stat_free_q != 16'hFFFF) stat_free_q <= stat_free_q + 16'd1;
            if (sat && stat_sat_q != 16'hFFFF) stat_sat_q <= stat_sat_q + 16'd1;
        end
    end

    assign stat_occ  = stat_occ_q;
    assign stat_free = stat_free_q;
    assign stat_sat  = stat_sat_q;
`endif
endmodule

// File: tb/tb_occupancy_map_updater.sv
// Directed bench for occupancy_map_updater: clear, saturation, burst forwarding, overflow, clear mid-RMW.
module tb_occupancy_map_updater;
    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              upd_valid = 1'b0, upd_free = 1'b0, clear_start = 1'b0;
    logic [4:0]        upd_x = '0, upd_y = '0, q_x = '0, q_y = '0;
    logic              upd_ready, clear_done, busy, overflow;
    logic signed [7:0] q_data;
`ifdef MAP_UPDATE_STATS_EN
    logic [15:0]       stat_occ, stat_free, stat_sat;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit saw_stall = 1'b0;

    int bx [10] = '{10, 10, 11, 11, 10, 10, 12, 12, 5, 5};
    int by [10] = '{10, 10, 10, 10, 10, 10, 3, 3, 20, 20};
    bit bf [10] = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 1};

    always #5 clock = ~clock;

    occupancy_map_updater dut (
        .clock      (clock),
        .reset      (reset),
        .upd_valid  (upd_valid),
        .upd_free   (upd_free),
        .upd_x      (upd_x),
        .upd_y      (upd_y),
        .upd_ready  (upd_ready),
        .clear_start(clear_start),
        .clear_done (clear_done),
        .q_x        (q_x),
        .q_y        (q_y),
        .q_data     (q_data),
        .busy       (busy),
        .overflow   (overflow)
`ifdef MAP_UPDATE_STATS_EN
        ,
        .stat_occ   (stat_occ),
        .stat_free  (stat_free),
        .stat_sat   (stat_sat)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Only raises valid when ready is already high, so honoured pushes never set overflow.
    task automatic push(input bit fr, input int x, input int y);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (upd_ready) begin
                upd_valid = 1'b1;
                upd_free  = fr;
                upd_x     = 5'(x);
                upd_y     = 5'(y);
                @(posedge clock);
                return;
            end
            upd_valid = 1'b0;
            saw_stall = 1'b1;
        end
        check("push_timeout", 0, 1);
    endtask

    task automatic release_upd();
        @(negedge clock);
        upd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (!busy) return;
        end
        check("idle_timeout", 0, 1);
    endtask

    task automatic read_cell(input int x, input int y, output int v);
        @(negedge clock);
        q_x = 5'(x);
        q_y = 5'(y);
        @(posedge clock);
        #1 v = int'(q_data);
    endtask

    // Called at the negedge right after the edge on which the FSM entered CLEAR.
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            if (clear_done) return;
        end
    endtask

    task automatic count_nonzero(output int nz);
        int v;
        nz = 0;
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++) begin
                read_cell(x, y, v);
                if (v != 0) nz++;
            end
    endtask

    task automatic issue_clear();
        @(negedge clock);
        clear_start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        clear_start = 1'b0;
    endtask

    initial begin
        int v, cyc, nz;

        repeat (3) @(negedge clock);
        check("rst_ready", upd_ready, 1);
        check("rst_clear_done", clear_done, 0);
        check("rst_q_data", int'(q_data), 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b0;

        issue_clear();
        check("clr_busy", busy, 1);
        check("clr_ready_low", upd_ready, 0);
        wait_done(cyc);
        check("clr_latency", cyc, 1024);
        @(negedge clock);
        check("clr_done_pulse", clear_done, 0);
        check("clr_busy_after", busy, 0);
        count_nonzero(nz);
        check("clr_map_zero", nz, 0);

        push(1'b0, 3, 5);
        release_upd();
        wait_idle();
        read_cell(3, 5, v);
        check("occ_3_5", v, 3);
        push(1'b1, 3, 5);
        release_upd();
        wait_idle();
        read_cell(3, 5, v);
        check("free_3_5", v, 2);

        repeat (50) push(1'b0, 0, 0);
        release_upd();
        wait_idle();
        read_cell(0, 0, v);
        check("sat_max", v, 127);
        read_cell(1, 0, v);
        check("neighbour_untouched", v, 0);
        repeat (300) push(1'b1, 0, 0);
        release_upd();
        wait_idle();
        read_cell(0, 0, v);
        check("sat_min", v, -128);
        check("sat_no_overflow", overflow, 0);
`ifdef MAP_UPDATE_STATS_EN
        check("stat_occ", stat_occ, 51);
        check("stat_free", stat_free, 301);
        check("stat_sat", stat_sat, 53);
`endif

        saw_stall = 1'b0;
        for (int i = 0; i < 10; i++) push(bf[i], bx[i], by[i]);
        release_upd();
        wait_idle();
        check("burst_ready_dropped", saw_stall, 1);
        check("burst_overflow", overflow, 0);
        read_cell(10, 10, v);
        check("burst_10_10", v, 8);
        read_cell(11, 10, v);
        check("burst_11_10", v, 2);
        read_cell(12, 3, v);
        check("burst_12_3", v, 6);
        read_cell(5, 20, v);
        check("burst_5_20", v, 2);

        repeat (8) push(1'b0, 25, 25);
        @(negedge clock);
        upd_valid = 1'b1;
        upd_free  = 1'b0;
        upd_x     = 5'd30;
        upd_y     = 5'd30;
        check("ovf_ready_low", upd_ready, 0);
        @(posedge clock);
        @(negedge clock);
        upd_valid = 1'b0;
        check("ovf_set", overflow, 1);
        wait_idle();
        check("ovf_sticky", overflow, 1);
        read_cell(25, 25, v);
        check("ovf_accepted", v, 24);
        read_cell(30, 30, v);
        check("ovf_dropped", v, 0);
        issue_clear();
        check("ovf_cleared", overflow, 0);
        wait_done(cyc);
        check("ovf_clr_latency", cyc, 1024);

        wait_idle();
        push(1'b0, 1, 1);
        push(1'b0, 2, 2);
        push(1'b0, 3, 3);
        push(1'b0, 4, 4);
        push(1'b0, 6, 6);
        @(negedge clock);
        clear_start = 1'b1;
        upd_valid   = 1'b1;
        upd_free    = 1'b0;
        upd_x       = 5'd7;
        upd_y       = 5'd7;
        @(posedge clock);
        @(negedge clock);
        clear_start = 1'b0;
        upd_valid   = 1'b0;
        check("mid_ready_low", upd_ready, 0);
        check("mid_no_overflow", overflow, 0);
        wait_done(cyc);
        check("mid_clr_latency", cyc, 1024);
        @(negedge clock);
        check("mid_busy_after", busy, 0);
        check("mid_overflow_after", overflow, 0);
        count_nonzero(nz);
        check("mid_map_zero", nz, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
        $fatal(1);
    end
endmodule
